// File: rtl/defines_package.sv
// -----------------------------------------------------------------------------
// defines_package
// Shared types for the polygon edge controller:
//   COORD_W   - width of one vertex coordinate
//   Point2D   - packed {x, y} vertex
//   EdgeState - controller state encoding (IDLE, CLEAR, SETUP, DRAW, DONE)
// -----------------------------------------------------------------------------
package defines_package;

  localparam int COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } Point2D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SETUP = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } EdgeState;

endpackage

// File: rtl/fb_clear_walker.sv
// -----------------------------------------------------------------------------
// fb_clear_walker
// Walks a linear framebuffer address from 0 to FB_W*FB_H-1, issuing one clear
// write per accepted cycle.
//   clk, n_rst - clock, asynchronous active-low reset
//   start      - one-cycle pulse that (re)starts the walk at address 0
//   ready      - framebuffer accepts the write this cycle
//   we         - clear write valid (high for the whole walk)
//   addr       - current linear address, held while ready is low
//   done       - one-cycle pulse when the final address is accepted
// Instantiated by primitive_edge_controller only when RASTER_CLEAR_EN is
// defined.
// -----------------------------------------------------------------------------
module fb_clear_walker #(
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter int ADDR_W = $clog2(FB_W * FB_H)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  logic              active_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fire;
  logic              at_last;

  assign fire    = active_q && ready;
  assign at_last = (addr_q == LAST_ADDR);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active_q <= 1'b0;
      addr_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      addr_q   <= '0;
    end else if (fire) begin
      if (at_last) begin
        active_q <= 1'b0;
        addr_q   <= '0;
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign we   = active_q;
  assign addr = addr_q;
  assign done = fire && at_last;

endmodule

// File: rtl/primitive_edge_controller.sv
// -----------------------------------------------------------------------------
// primitive_edge_controller
// Sequences the edges of a closed polygon into a Bresenham line drawer,
// optionally clearing the framebuffer first.
//   clk, n_rst   - clock, asynchronous active-low reset
//   start        - request to process a polygon (honoured only in IDLE)
//   verts        - vertex list, latched on the accepted start
//   vert_count   - number of valid vertices (clamped to MAX_VERTS)
//   bresen_done  - line drawer finished the current edge (used in DRAW only)
//   clr_ready    - framebuffer accepts a clear write
//   p, q         - current edge endpoints (zero outside SETUP/DRAW)
//   bresen_start - one-cycle launch pulse for the line drawer
//   edge_idx     - index of the edge in flight
//   clr_we       - clear write valid
//   clr_addr     - linear clear address
//   busy         - controller is not idle
//   done         - one-cycle completion pulse
// Build option: define RASTER_CLEAR_EN to add the CLEAR state and the
// framebuffer clear walker; otherwise clr_we and clr_addr are tied to 0.
// -----------------------------------------------------------------------------
module primitive_edge_controller
  import defines_package::*;
#(
  parameter int MAX_VERTS = 8,
  parameter int FB_W      = 640,
  parameter int FB_H      = 480
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             start,
  input  Point2D [MAX_VERTS-1:0]           verts,
  input  logic [$clog2(MAX_VERTS+1)-1:0]   vert_count,
  input  logic                             bresen_done,
  input  logic                             clr_ready,
  output Point2D                           p,
  output Point2D                           q,
  output logic                             bresen_start,
  output logic [$clog2(MAX_VERTS)-1:0]     edge_idx,
  output logic                             clr_we,
  output logic [$clog2(FB_W*FB_H)-1:0]     clr_addr,
  output logic                             busy,
  output logic                             done
);

  localparam int CNT_W  = $clog2(MAX_VERTS + 1);
  localparam int IDX_W  = $clog2(MAX_VERTS);
  localparam int ADDR_W = $clog2(FB_W * FB_H);

  EdgeState               state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       n_q, n_d;
  Point2D [MAX_VERTS-1:0] v_q;
  logic                   latch_en;

  logic [CNT_W-1:0]       n_in;
  logic [CNT_W-1:0]       n_m1;
  logic [CNT_W-1:0]       idx_inc;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       q_idx;
  logic                   in_edge;

  // Clamp the requested vertex count to the storage size.
  assign n_in = (vert_count > CNT_W'(MAX_VERTS)) ? CNT_W'(MAX_VERTS) : vert_count;

  // A two-vertex polygon is a single segment drawn once; otherwise the last
  // edge is the closing edge n-1 -> 0.
  assign n_m1     = n_q - CNT_W'(1);
  assign last_idx = (n_q == CNT_W'(2)) ? '0 : n_m1[IDX_W-1:0];

  // End-point index wraps to the latched vertex 0 on the closing edge.
  assign idx_inc = CNT_W'(idx_q) + CNT_W'(1);
  assign q_idx   = (idx_inc >= n_q) ? '0 : idx_inc[IDX_W-1:0];

`ifdef RASTER_CLEAR_EN
  logic              clr_start;
  logic              clr_done;
  logic [ADDR_W-1:0] walker_addr;
  logic              walker_we;

  fb_clear_walker #(
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .ADDR_W(ADDR_W)
  ) u_clear (
    .clk  (clk),
    .n_rst(n_rst),
    .start(clr_start),
    .ready(clr_ready),
    .we   (walker_we),
    .addr (walker_addr),
    .done (clr_done)
  );

  assign clr_we   = walker_we;
  assign clr_addr = walker_addr;
`else
  // Without the clear feature the ready input has no consumer.
  logic unused_clr_ready;
  assign unused_clr_ready = clr_ready;

  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    latch_en = 1'b0;
`ifdef RASTER_CLEAR_EN
    clr_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          idx_d    = '0;
          n_d      = n_in;
          if (n_in < CNT_W'(2)) begin
            state_d = ST_DONE;
          end else begin
`ifdef RASTER_CLEAR_EN
            clr_start = 1'b1;
            state_d   = ST_CLEAR;
`else
            state_d   = ST_SETUP;
`endif
          end
        end
      end
`ifdef RASTER_CLEAR_EN
      ST_CLEAR: begin
        if (clr_done) state_d = ST_SETUP;
      end
`endif
      ST_SETUP: begin
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (bresen_done) begin
          if (idx_q == last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
    end
  end

  // NOTE: the vertex store is small and must read back as zero after reset,
  // so unlike a RAM it sits inside the reset branch.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v_q <= '0;
    end else if (latch_en) begin
      v_q <= verts;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign in_edge      = (state_q == ST_SETUP) || (state_q == ST_DRAW);
  assign p            = in_edge ? v_q[idx_q] : '0;
  assign q            = in_edge ? v_q[q_idx] : '0;
  assign bresen_start = (state_q == ST_SETUP);
  assign edge_idx     = idx_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_primitive_edge_controller.sv
// -----------------------------------------------------------------------------
// tb_primitive_edge_controller
// Directed bench for primitive_edge_controller (MAX_VERTS=8, FB_W=4, FB_H=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Works with and without RASTER_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_primitive_edge_controller;
  import defines_package::*;

  localparam int MV = 8;
  localparam int FW = 4;
  localparam int FH = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  Point2D [MV-1:0] verts;
  logic [3:0]    vert_count = '0;
  logic          bresen_done = 1'b0;
  logic          clr_ready = 1'b0;
  Point2D        p, q;
  logic          bresen_start;
  logic [2:0]    edge_idx;
  logic          clr_we;
  logic [2:0]    clr_addr;
  logic          busy, done;

  int tests = 0;
  int fails = 0;

  primitive_edge_controller #(
    .MAX_VERTS(MV),
    .FB_W     (FW),
    .FB_H     (FH)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .verts       (verts),
    .vert_count  (vert_count),
    .bresen_done (bresen_done),
    .clr_ready   (clr_ready),
    .p           (p),
    .q           (q),
    .bresen_start(bresen_start),
    .edge_idx    (edge_idx),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // clr_ready toggles every cycle, away from both clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #2 clr_ready = ~clr_ready;
    end
  end

  // Observers: launch pulses and accepted clear writes.
  int         bs_count = 0;
  int         wr_count = 0;
  int         wr_bad   = 0;
  int         hits [FW*FH];
  logic [2:0] exp_addr = '0;

  initial for (int i = 0; i < FW*FH; i++) hits[i] = 0;

  always @(negedge clk) begin
    if (bresen_start === 1'b1) bs_count++;
    if (clr_we === 1'b1 && clr_ready === 1'b1) begin
      wr_count++;
      hits[clr_addr]++;
      if (clr_addr !== exp_addr) wr_bad++;
      exp_addr = (clr_addr == 3'd7) ? 3'd0 : clr_addr + 3'd1;
    end
  end

  function automatic Point2D pt(input int x, input int y);
    Point2D r;
    r.x = 16'(x);
    r.y = 16'(y);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until bresen_start is seen at a falling edge.
  task automatic wait_bs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bresen_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic start_poly(input int cnt);
    vert_count = 4'(cnt);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Follows one edge: checks endpoints in SETUP and DRAW, optionally pokes
  // start mid-DRAW, then returns bresen_done 4 cycles after the launch.
  task automatic do_edge(input int e, input Point2D ep, input Point2D eq, input bit poke);
    bit ok;
    wait_bs(ok);
    check($sformatf("e%0d_launch", e), 64'(ok), 64'd1);
    check($sformatf("e%0d_idx", e), 64'(edge_idx), 64'(e));
    check($sformatf("e%0d_p", e), 64'(p), 64'(ep));
    check($sformatf("e%0d_q", e), 64'(q), 64'(eq));
    @(negedge clk);
    check($sformatf("e%0d_pulse_len", e), 64'(bresen_start), 64'd0);
    check($sformatf("e%0d_draw_p", e), 64'(p), 64'(ep));
    if (poke) begin
      start      = 1'b1;
      vert_count = 4'd2;
    end
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      check("poke_busy", 64'(busy), 64'd1);
      check("poke_idx", 64'(edge_idx), 64'(e));
      check("poke_p", 64'(p), 64'(ep));
      check("poke_q", 64'(q), 64'(eq));
    end
    @(negedge clk);
    bresen_done = 1'b1;
    @(negedge clk);
    bresen_done = 1'b0;
  endtask

  Point2D [MV-1:0] saved;
  int bs0;
  int wr0;
  bit ok_main;

  initial begin
    verts = '0;

    // ---- reset state ------------------------------------------------------
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bs", 64'(bresen_start), 64'd0);
    check("rst_idx", 64'(edge_idx), 64'd0);
    check("rst_pq", {p, q}, 64'd0);
    check("rst_clr", {60'd0, clr_we, clr_addr}, 64'd0);
    n_rst = 1'b1;
    bresen_done = 1'b1;               // must be ignored in IDLE
    @(negedge clk);
    bresen_done = 1'b0;
    check("idle_bdone_ignored", 64'(busy), 64'd0);

    // ---- triangle ---------------------------------------------------------
    verts[0] = pt(0, 0);
    verts[1] = pt(10, 0);
    verts[2] = pt(0, 10);
    bs0 = bs_count;
    wr0 = wr_count;
    start_poly(3);
    check("tri_busy", 64'(busy), 64'd1);
`ifdef RASTER_CLEAR_EN
    check("tri_clear_we", 64'(clr_we), 64'd1);
    check("tri_clear_addr0", 64'(clr_addr), 64'd0);
    check("tri_no_early_bs", 64'(bresen_start), 64'd0);
`else
    check("tri_direct_setup", 64'(bresen_start), 64'd1);
`endif
    do_edge(0, pt(0, 0), pt(10, 0), 1'b0);
`ifdef RASTER_CLEAR_EN
    check("clr_writes", 64'(wr_count - wr0), 64'd8);
    check("clr_order", 64'(wr_bad), 64'd0);
    for (int a = 0; a < FW*FH; a++)
      check($sformatf("clr_hit%0d", a), 64'(hits[a]), 64'd1);
`endif
    do_edge(1, pt(10, 0), pt(0, 10), 1'b0);
    do_edge(2, pt(0, 10), pt(0, 0), 1'b0);
    check("tri_done", 64'(done), 64'd1);
    check("tri_done_busy", 64'(busy), 64'd1);
    check("tri_done_idx", 64'(edge_idx), 64'd2);
    check("tri_done_pq", {p, q}, 64'd0);
    vert_count = 4'd3;
    start      = 1'b1;                // ignored in the DONE cycle
    @(negedge clk);
    start      = 1'b0;
    check("tri_done_len", 64'(done), 64'd0);
    check("done_start_ignored", 64'(busy), 64'd0);
    check("idx_held", 64'(edge_idx), 64'd2);
    check("tri_pulses", 64'(bs_count - bs0), 64'd3);

    // ---- two vertices: one edge -------------------------------------------
    verts[0] = pt(5, 5);
    verts[1] = pt(9, 9);
    bs0 = bs_count;
    start_poly(2);
    do_edge(0, pt(5, 5), pt(9, 9), 1'b0);
    check("n2_done", 64'(done), 64'd1);
    @(negedge clk);
    check("n2_idle", 64'(busy), 64'd0);
    check("n2_pulses", 64'(bs_count - bs0), 64'd1);

    // ---- one vertex: degenerate -------------------------------------------
    bs0 = bs_count;
    wr0 = wr_count;
    start_poly(1);
    check("n1_done", 64'(done), 64'd1);
    check("n1_no_bs", 64'(bresen_start), 64'd0);
    check("n1_no_clear", 64'(clr_we), 64'd0);
    @(negedge clk);
    check("n1_done_len", 64'(done), 64'd0);
    check("n1_pulses", 64'(bs_count - bs0), 64'd0);
    check("n1_writes", 64'(wr_count - wr0), 64'd0);

    // ---- vert_count clamp, input changes after acceptance, mid-DRAW start --
    for (int i = 0; i < MV; i++) verts[i] = pt(i + 1, 20 + i);
    saved = verts;
    bs0 = bs_count;
    start_poly(12);
    for (int i = 0; i < MV; i++) verts[i] = pt(16'hBEEF, 16'hBEEF);
    for (int e = 0; e < MV; e++)
      do_edge(e, saved[e], saved[(e + 1) % MV], (e == 3));
    check("n8_done", 64'(done), 64'd1);
    check("n8_last_idx", 64'(edge_idx), 64'd7);
    check("n8_pulses", 64'(bs_count - bs0), 64'd8);
    @(negedge clk);

    // ---- asynchronous reset during DRAW of edge 1 --------------------------
    verts[0] = pt(0, 0);
    verts[1] = pt(10, 0);
    verts[2] = pt(0, 10);
    start_poly(3);
    do_edge(0, pt(0, 0), pt(10, 0), 1'b0);
    wait_bs(ok_main);
    check("rst_mid_launch", 64'(ok_main), 64'd1);
    check("rst_mid_idx", 64'(edge_idx), 64'd1);
    @(negedge clk);                   // now in DRAW of edge 1
    #2 n_rst = 1'b0;
    #1;
    check("arst_pq", {p, q}, 64'd0);
    check("arst_idx", 64'(edge_idx), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_bs", 64'(bresen_start), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    start_poly(3);
    do_edge(0, pt(0, 0), pt(10, 0), 1'b0);
    do_edge(1, pt(10, 0), pt(0, 10), 1'b0);
    do_edge(2, pt(0, 10), pt(0, 0), 1'b0);
    check("restart_done", 64'(done), 64'd1);
    @(negedge clk);

`ifdef RASTER_CLEAR_EN
    check("clr_order_all", 64'(wr_bad), 64'd0);
`else
    check("no_clear_writes", 64'(wr_count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
